// File: rtl/ram_n_clr.sv
`default_nettype none
// ============================================================================
// Module   : ram_n_clr
// Brief    : 2**ADDR_W x WIDTH register-file RAM with two combinational read
//            ports and a one-word-per-cycle bulk-clear sweep.
// Revision : 1.0
// ============================================================================
module ram_n_clr #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [WIDTH-1:0]                       in,
    input  logic [((ADDR_W > 0) ? ADDR_W : 1)-1:0] address,
    input  logic                                   load,
    input  logic [((ADDR_W > 0) ? ADDR_W : 1)-1:0] address_b,
    input  logic                                   clear,
    output logic [WIDTH-1:0]                       out,
    output logic [WIDTH-1:0]                       out_b,
    output logic                                   busy
);

    localparam int c_aw    = (ADDR_W > 0) ? ADDR_W : 1;
    localparam int c_depth = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic   [c_aw-1:0]               r_ptr;
    logic   [c_aw-1:0]               w_ptr_next;
    logic   [c_depth-1:0][WIDTH-1:0] r_mem;
    logic   [c_depth-1:0]            w_wr_en;
    logic   [c_depth-1:0]            w_clr_en;
    logic   [c_aw-1:0]               w_addr_a;
    logic   [c_aw-1:0]               w_addr_b;

    // A zero-bit address still arrives as one port bit; it must not select anything.
    assign w_addr_a = (ADDR_W == 0) ? '0 : address;
    assign w_addr_b = (ADDR_W == 0) ? '0 : address_b;

    assign busy = (r_state == ST_CLEARING);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clear) begin
                    w_state_next = ST_CLEARING;
                    w_ptr_next   = '0;
                end
            end
            ST_CLEARING: begin
                if (r_ptr == c_aw'(c_depth - 1)) begin
                    w_state_next = ST_IDLE;
                    w_ptr_next   = '0;
                end else begin
                    w_ptr_next = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ptr_next   = '0;
            end
        endcase
    end

    // User writes are locked out for the whole sweep; the sweep owns the array.
    always_comb begin
        w_wr_en  = '0;
        w_clr_en = '0;
        for (int i = 0; i < c_depth; i++) begin
            w_wr_en[i]  = load && (r_state == ST_IDLE) && (w_addr_a == c_aw'(i));
            w_clr_en[i] = (r_state == ST_CLEARING) && (r_ptr == c_aw'(i));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem <= '0;
        end else begin
            for (int i = 0; i < c_depth; i++) begin
                if (w_clr_en[i]) begin
                    r_mem[i] <= '0;
                end else if (w_wr_en[i]) begin
                    r_mem[i] <= in;
                end
            end
        end
    end

    always_comb begin
        out   = '0;
        out_b = '0;
        for (int i = 0; i < c_depth; i++) begin
            if (w_addr_a == c_aw'(i)) begin
                out = r_mem[i];
            end
            if (w_addr_b == c_aw'(i)) begin
                out_b = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_n_clr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ram_n_clr
// Brief    : Randomised and directed checks of ram_n_clr in four geometries
//            against an array/countdown reference model.
// Revision : 1.0
// ============================================================================
module tb_ram_n_clr;

    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic        clear;
    logic [15:0] din;
    logic [5:0]  ad  [4];
    logic [5:0]  adb [4];

    logic [15:0] out0, outb0;
    logic [7:0]  out1, outb1;
    logic [15:0] out2, outb2;
    logic [0:0]  out3, outb3;
    logic        busy0, busy1, busy2, busy3;

    logic [15:0] o_out  [4];
    logic [15:0] o_outb [4];
    logic        o_busy [4];

    always #5 clock = ~clock;

    ram_n_clr #(.WIDTH(16), .ADDR_W(3)) u_dut0 (
        .clock(clock), .reset(reset), .in(din), .address(ad[0][2:0]), .load(load),
        .address_b(adb[0][2:0]), .clear(clear), .out(out0), .out_b(outb0), .busy(busy0));
    ram_n_clr #(.WIDTH(8), .ADDR_W(1)) u_dut1 (
        .clock(clock), .reset(reset), .in(din[7:0]), .address(ad[1][0:0]), .load(load),
        .address_b(adb[1][0:0]), .clear(clear), .out(out1), .out_b(outb1), .busy(busy1));
    ram_n_clr #(.WIDTH(16), .ADDR_W(6)) u_dut2 (
        .clock(clock), .reset(reset), .in(din), .address(ad[2]), .load(load),
        .address_b(adb[2]), .clear(clear), .out(out2), .out_b(outb2), .busy(busy2));
    ram_n_clr #(.WIDTH(1), .ADDR_W(0)) u_dut3 (
        .clock(clock), .reset(reset), .in(din[0:0]), .address(ad[3][0:0]), .load(load),
        .address_b(adb[3][0:0]), .clear(clear), .out(out3), .out_b(outb3), .busy(busy3));

    always_comb begin
        o_out[0]  = out0;              o_outb[0] = outb0;
        o_out[1]  = {8'h00, out1};     o_outb[1] = {8'h00, outb1};
        o_out[2]  = out2;              o_outb[2] = outb2;
        o_out[3]  = {15'h0000, out3};  o_outb[3] = {15'h0000, outb3};
        o_busy[0] = busy0; o_busy[1] = busy1; o_busy[2] = busy2; o_busy[3] = busy3;
    end

    // Reference: word contents plus "sweep edges remaining" per instance.
    logic [15:0] mm [4][64];
    int          sw [4];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cnt [4];

    function automatic int depth(input int k);
        case (k)
            0:       return 8;
            1:       return 2;
            2:       return 64;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] wmask(input int k);
        case (k)
            1:       return 16'h00FF;
            3:       return 16'h0001;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            sw[k] = 0;
            for (int a = 0; a < 64; a++) mm[k][a] = 16'h0000;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            int d;
            d = depth(k);
            if (sw[k] > 0) begin
                mm[k][d - sw[k]] = 16'h0000;
                sw[k]--;
            end else begin
                if (load) mm[k][int'(ad[k]) & (d - 1)] = din & wmask(k);
                if (clear) sw[k] = d;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            int d;
            d = depth(k);
            check($sformatf("out[%0d]", k),   o_out[k],  mm[k][int'(ad[k]) & (d - 1)]);
            check($sformatf("out_b[%0d]", k), o_outb[k], mm[k][int'(adb[k]) & (d - 1)]);
            check($sformatf("busy[%0d]", k),  o_busy[k], sw[k] > 0);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check_all();
    endtask

    task automatic set_all_addr(input int a);
        for (int k = 0; k < 4; k++) begin
            ad[k]  = 6'(a);
            adb[k] = 6'(a);
        end
    endtask

    task automatic set_addr_rand();
        for (int k = 0; k < 4; k++) begin
            ad[k]  = 6'($urandom_range(0, 63));
            adb[k] = 6'($urandom_range(0, 63));
        end
    endtask

    // Only used while nothing can change state (reset held or all idle, no load/clear).
    task automatic read_sweep();
        for (int a = 0; a < 64; a++) begin
            for (int k = 0; k < 4; k++) begin
                ad[k]  = 6'(a);
                adb[k] = 6'(63 - a);
            end
            #1;
            check_all();
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; load = 1'b0; clear = 1'b0; din = 16'h0000;
        set_all_addr(0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        read_sweep();
        check("busy_in_reset", busy0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Write/readback and absence of write-through.
        load = 1'b1; din = 16'h1234; set_all_addr(5);
        tick();
        din = 16'hBEEF; set_all_addr(2);
        tick();
        load = 1'b0; ad[0] = 6'd5; adb[0] = 6'd2;
        #1;
        check("rd_a_5", out0, 16'h1234);
        check("rd_b_2", outb0, 16'hBEEF);
        check_all();
        load = 1'b1; din = 16'h5555;
        #1;
        check("no_bypass", out0, 16'h1234);
        tick();
        check("wr_visible", out0, 16'h5555);
        load = 1'b0;

        // Bulk clear with progressive-zero checks on the 8-word instance.
        load = 1'b1; din = 16'hA5A5;
        for (int a = 0; a < 64; a++) begin
            set_all_addr(a);
            tick();
        end
        load = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        for (int j = 0; j < 70; j++) begin
            for (int k = 0; k < 4; k++) if (o_busy[k]) cnt[k]++;
            set_addr_rand();
            if (j >= 1 && j <= 7) begin
                ad[0]  = 6'(j - 1);
                adb[0] = 6'(j);
            end
            #1;
            check_all();
            if (j >= 1 && j <= 7) begin
                check("swept_word", out0, 16'h0000);
                check("unswept_word", outb0, 16'hA5A5);
            end
            tick();
        end
        check("busy_len_d8", cnt[0], 8);
        check("busy_len_d2", cnt[1], 2);
        check("busy_len_d64", cnt[2], 64);
        check("busy_len_d1", cnt[3], 1);
        read_sweep();

        // Loads during the sweep are dropped.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        load = 1'b1; din = 16'h7777; set_all_addr(7);
        tick();
        load = 1'b0;
        repeat (70) tick();
        ad[0] = 6'd7;
        #1;
        check("blocked_wr", out0, 16'h0000);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("post_busy_wr", out0, 16'h7777);

        // Simultaneous clear+load, then re-clear mid-sweep.
        set_all_addr(0); din = 16'h0F0F; load = 1'b1; clear = 1'b1;
        tick();
        load = 1'b0; clear = 1'b0;
        check("sim_load_kept", out0, 16'h0F0F);
        cnt[0] = busy0 ? 1 : 0;
        for (int j = 0; j < 20; j++) begin
            clear = (j >= 2 && j <= 4);
            tick();
            if (j == 0) check("sim_load_swept", out0, 16'h0000);
            if (busy0) cnt[0]++;
        end
        clear = 1'b0;
        check("no_restart_len", cnt[0], 8);
        repeat (70) tick();

        // Randomised traffic.
        repeat (1500) begin
            set_addr_rand();
            din   = 16'($urandom);
            load  = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 40) == 0);
            tick();
        end
        load = 1'b0; clear = 1'b0;
        repeat (70) tick();

        // Asynchronous reset after sweep edge 3 of the 64-word instance.
        load = 1'b1;
        for (int a = 0; a < 64; a++) begin
            set_all_addr(a);
            din = 16'($urandom) | 16'h0101;
            tick();
        end
        load = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        ad[2] = 6'd40;
        #1;
        check("pre_rst_data", out2 != 16'h0000, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_busy_async", busy2, 1'b0);
        check("rst_data_async", out2, 16'h0000);
        read_sweep();
        @(negedge clock);
        reset = 1'b0;
        set_addr_rand();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_n_clr.md
Name: ram_n_clr

Overview:
- Parametrised register-file RAM: 2**ADDR_W words of WIDTH bits, one write port and two independent combinational read ports.
- Built-in sequential bulk-clear engine zeroes every word, one word per cycle, under a start/busy handshake.
- Generalises the fixed 8 x 16 RAM stage to arbitrary width and depth, and to a second read channel.
- Serves as the base storage block for the larger RAM tiers and the data memory.

Parameters:
- WIDTH, 16, bits per word (>=1)
- ADDR_W, 3, address bits; DEPTH = 2**ADDR_W words (>=1)

Ports:
- clock  input  1  rising-edge clock for all state
- reset  input  1  asynchronous, active-high reset
- in  input  WIDTH  write data
- address  input  ADDR_W  write address and port-A read address
- load  input  1  write enable for port A
- address_b  input  ADDR_W  port-B read address
- clear  input  1  bulk-clear start request, sampled on the rising edge
- out  output  WIDTH  port-A read data, mem[address]
- out_b  output  WIDTH  port-B read data, mem[address_b]
- busy  output  1  high while the clear sweep runs

Behaviour:
- Reset (asynchronous, active-high): all DEPTH words go to 0, state goes to IDLE, sweep pointer goes to 0, busy = 0. Because out and out_b are combinational reads of storage, both read 0 while reset is asserted and immediately after it. Reset asserted mid-sweep aborts the sweep at once: every word reads 0 and busy = 0 with no further clock edge.
- Reads: out = mem[address] and out_b = mem[address_b], both purely combinational with zero latency. A write becomes visible on the reads only after the rising edge that performs it; there is no write-through bypass. The two ports may use the same address and then return identical data.
- Writes:
  - State IDLE: load = 1 at a rising edge stores in into mem[address].
  - State CLEARING: load is ignored and no user write occurs. Software must poll busy before writing.
- State machine, two states: IDLE, CLEARING.
  - IDLE to CLEARING: clear = 1 at a rising edge. At that edge ptr is set to 0 and busy goes to 1. A load on the same edge is still honoured, and that word is later zeroed by the sweep.
  - CLEARING: at each rising edge mem[ptr] is set to 0.
    - If ptr == DEPTH-1: state goes to IDLE, busy goes to 0, ptr goes to 0.
    - Otherwise ptr increments by 1.
  - The sweep lasts exactly DEPTH edges after the start edge. busy is high for DEPTH cycles.
  - clear = 1 while in CLEARING is ignored; the sweep does not restart.
  - For DEPTH = 1 the sweep is one edge long.
- Reads during CLEARING return the current contents: words below ptr already read 0, words at or above ptr still hold their old data.
- ptr is ADDR_W bits wide. It never wraps inside a sweep because termination happens at DEPTH-1.
- Unknown (X) or out-of-range values cannot occur, because every address value maps to a valid word.
- Structure: write decode as a DEPTH-way demux ANDed with load and not-busy; storage as DEPTH WIDTH-bit registers; two DEPTH-way read muxes.

Test Plan:
- Reset then read: assert reset mid-run; all 8 words, checked via address and address_b sweeps, read 0x0000; busy = 0.
- Write/readback: write 0x1234 to addr 5 and 0xBEEF to addr 2.
  - Set address=5, address_b=2: out = 0x1234, out_b = 0xBEEF.
  - With load high and new data applied, out keeps its old value until the next edge.
- Bulk clear: fill all words with 0xA5A5, pulse clear for 1 cycle.
  - busy is high for exactly 8 cycles.
  - After k sweep edges, words 0..k-1 read 0 and words k..7 read 0xA5A5.
  - After the sweep all words read 0.
- Write blocked while busy: during the sweep, load 0x7777 to addr 7 at sweep edge 2. After the sweep, addr 7 reads 0. Loads after busy falls succeed.
- Simultaneous clear+load: on the same edge, load 0x0F0F to addr 0 and assert clear. Addr 0 reads 0x0F0F for one cycle, then reads 0 after the first sweep edge. A repeated clear mid-sweep does not extend busy beyond 8 cycles.
- Parameter sweep: WIDTH=8/ADDR_W=1, WIDTH=16/ADDR_W=6, WIDTH=1/ADDR_W=0. Repeat the write/readback and bulk-clear checks; busy length equals DEPTH (2, 64, 1). Assert reset during sweep edge 3 of the 64-word instance: busy falls asynchronously and all words read 0.
